// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter: frame levels, data width
// and the frame-sequencing state encoding.
package uart_tx_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Even parity is the XOR of the byte; odd parity is its inverse.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer: state register, data-bit counter, next-state logic and BUSY.
// Next state and next count are exported so the top can register TX_OUT in step.
module uart_tx_fsm
    import uart_tx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic             par_en,
    output state_t           state_nxt,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             accept,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Requests are taken only when idle or on the stop bit (back-to-back frames).
    assign accept = data_valid && (state == IDLE || state == STOP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE:   if (accept) state_nxt = START;
            START:  state_nxt = DATA;
            DATA: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_W'(DATA_W - 1))
                    state_nxt = par_en ? PARITY : STOP;
            end
            PARITY: state_nxt = STOP;
            STOP:   state_nxt = accept ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter, one bit per clock: start, 8 data bits LSB first, optional
// even/odd parity, one stop bit. Holds the request latch and the registered line driver.
module uart_tx_top
    import uart_tx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] PAR_DATA,
    input  logic              DATA_VALID,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              TX_OUT,
    output logic              BUSY
);

    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               accept;
    logic [DATA_W-1:0]  data_lat;
    logic               par_en_lat;
    logic               par_typ_lat;
    logic               tx_nxt;

    uart_tx_fsm u_fsm (
        .clk        (CLK),
        .rst        (RST),
        .data_valid (DATA_VALID),
        .par_en     (par_en_lat),
        .state_nxt  (state_nxt),
        .cnt_nxt    (cnt_nxt),
        .accept     (accept),
        .busy       (BUSY)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_lat    <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
        end else if (accept) begin
            data_lat    <= PAR_DATA;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
        end
    end

    // Line level is chosen for the state being entered, so TX_OUT is a plain register.
    always_comb begin
        tx_nxt = IDLE_LEVEL;
        case (state_nxt)
            START:  tx_nxt = START_BIT;
            DATA:   tx_nxt = data_lat[cnt_nxt];
            PARITY: tx_nxt = parity_bit(data_lat, par_typ_lat);
            STOP:   tx_nxt = STOP_BIT;
            default: tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) TX_OUT <= IDLE_LEVEL;
        else     TX_OUT <= tx_nxt;
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// Self-checking bench for uart_tx_top: directed frame table, hand-written corner
// sequences and randomized traffic against a frame-queue reference model.
module tb_uart_tx_top;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] PAR_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: queue of line levels still to be sent; element 0 is on the line now.
    logic q[$];
    logic exp_tx;
    logic exp_busy;

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        ptyp;
        int          len;
        logic [10:0] bits;
        int          ign_at;
        logic        chain;
    } vec_t;

    vec_t vecs[5];

    uart_tx_top dut (
        .CLK        (CLK),
        .RST        (RST),
        .PAR_DATA   (PAR_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit acc;
        int ones;
        if (RST) begin
            q.delete();
        end else begin
            acc = DATA_VALID && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                q.push_back(1'b0);
                for (int i = 0; i < 8; i++) q.push_back(PAR_DATA[i]);
                if (PAR_EN) begin
                    ones = $countones(PAR_DATA);
                    q.push_back(PAR_TYP ? logic'(1 - ones % 2) : logic'(ones % 2));
                end
                q.push_back(1'b1);
            end
        end
        exp_tx   = (q.size() > 0) ? q[0] : 1'b1;
        exp_busy = (q.size() > 0);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check("model_tx", TX_OUT, exp_tx);
        check("model_busy", BUSY, exp_busy);
    endtask

    initial begin
        vecs[0] = '{8'h1B, 1'b1, 1'b1, 11, 11'b11000110110, -1, 1'b1};
        vecs[1] = '{8'h69, 1'b1, 1'b0, 11, 11'b10011010010, -1, 1'b0};
        vecs[2] = '{8'h2D, 1'b0, 1'b0, 10, 11'b01001011010, -1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 10, 11'b01000000000,  4, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 11, 11'b10111111110, -1, 1'b0};

        RST = 1'b1; DATA_VALID = 1'b1; PAR_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0;

        // Reset wins over a simultaneous request.
        cycle();
        check("rst_tx", TX_OUT, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        cycle();
        RST = 1'b0; DATA_VALID = 1'b0;
        cycle();
        check("post_rst_tx", TX_OUT, 1'b1);
        check("post_rst_busy", BUSY, 1'b0);

        begin
            logic chained = 1'b0;
            for (int v = 0; v < 5; v++) begin
                if (!chained) begin
                    PAR_DATA = vecs[v].data; PAR_EN = vecs[v].pen; PAR_TYP = vecs[v].ptyp;
                    DATA_VALID = 1'b1;
                end
                for (int b = 0; b < vecs[v].len; b++) begin
                    cycle();
                    DATA_VALID = 1'b0;
                    PAR_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
                    check($sformatf("vec%0d_bit%0d", v, b), TX_OUT, vecs[v].bits[b]);
                    check($sformatf("vec%0d_busy%0d", v, b), BUSY, 1'b1);
                    if (b == vecs[v].ign_at) begin
                        PAR_DATA = 8'hFF; PAR_EN = 1'b1; DATA_VALID = 1'b1;
                    end
                    if (b == vecs[v].len - 1 && vecs[v].chain && v < 4) begin
                        PAR_DATA = vecs[v+1].data; PAR_EN = vecs[v+1].pen;
                        PAR_TYP = vecs[v+1].ptyp; DATA_VALID = 1'b1;
                    end
                end
                chained = vecs[v].chain;
                if (!chained) begin
                    cycle();
                    check($sformatf("vec%0d_idle_tx", v), TX_OUT, 1'b1);
                    check($sformatf("vec%0d_idle_busy", v), BUSY, 1'b0);
                end
            end
        end

        // Reset during data bit 3 of an 0xA5 frame, then a clean frame.
        PAR_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        cycle();
        DATA_VALID = 1'b0;
        repeat (4) cycle();
        check("abort_bit3", TX_OUT, 1'b0);
        RST = 1'b1;
        cycle();
        check("abort_tx", TX_OUT, 1'b1);
        check("abort_busy", BUSY, 1'b0);
        RST = 1'b0;
        PAR_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
        cycle();
        DATA_VALID = 1'b0;
        check("restart_start", TX_OUT, 1'b0);
        repeat (10) cycle();
        check("restart_stop", TX_OUT, 1'b1);
        check("restart_stop_busy", BUSY, 1'b1);
        cycle();
        check("restart_idle_busy", BUSY, 1'b0);

        // Randomized traffic: requests at any time, live inputs churning, rare resets.
        for (int i = 0; i < 3000; i++) begin
            RST        = ($urandom_range(0, 199) == 0);
            DATA_VALID = ($urandom_range(0, 3) == 0);
            PAR_DATA   = 8'($urandom);
            PAR_EN     = 1'($urandom);
            PAR_TYP    = 1'($urandom);
            cycle();
        end
        RST = 1'b0; DATA_VALID = 1'b0;
        repeat (12) cycle();
        check("final_idle_busy", BUSY, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Top-level UART transmitter that serializes one parallel byte per request into an asynchronous serial frame. The frame is a start bit, 8 data bits LSB first, an optional even/odd parity bit and one stop bit. It transmits at one bit per clock; any baud-rate division happens upstream in the clock source. It sits between a byte producer, which uses a valid-only handshake and watches BUSY, and the serial line.

## Interface
- No parameters. Data width is fixed at 8.
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- PAR_DATA  in  8  byte to transmit; sampled only when a request is accepted.
- DATA_VALID  in  1  transmit request; single-cycle pulse is sufficient.
- PAR_EN  in  1  1 = insert parity bit; sampled with PAR_DATA.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled with PAR_DATA.
- TX_OUT  out  1  serial line, registered; idles high.
- BUSY  out  1  registered; high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, BUSY=0.
  - Request accepted when DATA_VALID=1 at a clock edge. On that edge, latch PAR_DATA, PAR_EN and PAR_TYP, then go to START.
- START: TX_OUT=0 for 1 cycle, then go to DATA.
- DATA: TX_OUT = latched bit[i], i = 0..7, LSB first, 1 cycle each. A 3-bit counter counts 0..7 and wraps to 0.
  - After bit 7, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: 1 cycle.
  - Even (PAR_TYP=0): TX_OUT = XOR of latched data.
  - Odd (PAR_TYP=1): TX_OUT = inverted XOR of latched data.
  - Then go to STOP.
- STOP: TX_OUT=1 for 1 cycle.
  - If DATA_VALID=1 during this cycle: the request is accepted, inputs are latched, and the next state is START. This gives back-to-back frames with no idle bit, and BUSY stays 1.
  - Otherwise go to IDLE.
- DATA_VALID asserted in START, DATA or PARITY is ignored and not queued.
- Input changes after acceptance do not affect the frame in progress.
- Parity is computed from the latched byte, never from the live PAR_DATA.

## Timing
- Reset (RST=1 at an edge): state=IDLE, TX_OUT=1, BUSY=0, counter=0, latched data=0.
  - Reset wins over DATA_VALID.
  - Reset mid-frame aborts immediately; TX_OUT returns to 1 on the next edge.
- Latency: acceptance at edge k. TX_OUT shows the start bit and BUSY=1 in the cycle after edge k.
- Frame length: 11 cycles with parity, 10 cycles without, start through stop inclusive.
- BUSY is 1 exactly while the state is not IDLE, including STOP.
- BUSY drops in the cycle after STOP, unless a back-to-back request was accepted.
- TX_OUT and BUSY are glitch-free register outputs. There is no combinational path from inputs to outputs.

## Structure
- Shared package `uart_tx_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1;
  - DATA_W=8.
- One sub-module, `uart_tx_fsm`: state register, bit counter, next-state logic and BUSY generation.
- The top holds the input latch, parity calculation and the registered TX_OUT mux, and instantiates `uart_tx_fsm`.

## Test plan
- Reset: RST=1 for one edge -> TX_OUT=1, BUSY=0. With DATA_VALID=1 during reset, no frame starts.
- 0x1B, PAR_EN=1, PAR_TYP=1 (odd), 1-cycle DATA_VALID.
  - TX_OUT sequence: 0,1,1,0,1,1,0,0,0,1,1 (start, data LSB first, parity=1, stop).
  - BUSY high for exactly 11 cycles.
- Back-to-back: pulse DATA_VALID with 0x69, PAR_EN=1, PAR_TYP=0 (even) during the stop bit of the previous frame.
  - Next start bit follows the stop bit directly; BUSY never drops.
  - Frame: 0,1,0,0,1,0,1,1,0,0,1 (even parity=0).
- No parity: 0x2D, PAR_EN=0, launched from IDLE.
  - Frame: 0,1,0,1,1,0,1,0,0,1 (10 cycles); then IDLE with TX_OUT=1, BUSY=0.
- Ignored request: pulse DATA_VALID with 0xFF in the DATA state of a 0x00 frame.
  - The 0x00 frame is unchanged; no second frame follows.
- Mid-frame reset: assert RST during data bit 3.
  - Next cycle TX_OUT=1, BUSY=0.
  - A new request afterwards produces a clean full frame.
